// File: rtl/sha3_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha3_padder
// Brief    : Packs a byte stream into rate blocks and applies SHA3 padding
//            (60 .. 00 .. 01, merged as 61) for the keccak message input.
// Revision : 1.0 - initial release
// ============================================================================
module sha3_padder #(
    parameter int D = 256,
    parameter int R = 1600 - 2 * D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [R-1:0] block,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);
    localparam int RB = R / 8;
    localparam int CW = $clog2(RB);
    localparam logic [CW-1:0] CNT_LAST = CW'(RB - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [R-1:0]  shreg;
    logic [CW-1:0] cnt, cnt_n;
    logic          pad_pending, pad_pending_n;
    logic          first_pad, first_pad_n;
    logic          last_r, last_n;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          accept;
    logic          cnt_full;

    assign in_ready    = (state == FILL) && !reset;
    assign accept      = in_valid && in_ready;
    assign cnt_full    = (cnt == CNT_LAST);
    assign block       = shreg;
    assign block_valid = (state == OUT);
    assign block_last  = last_r;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pad_pending_n = pad_pending;
        first_pad_n   = first_pad;
        last_n        = last_r;
        wr_en         = 1'b0;
        wr_byte       = in_data;
        case (state)
            FILL: begin
                if (accept) begin
                    if (!in_last) begin
                        wr_en = 1'b1;
                        if (cnt_full) begin
                            cnt_n   = '0;
                            last_n  = 1'b0;
                            state_n = OUT;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (!in_empty) begin
                        wr_en = 1'b1;
                        if (cnt_full) begin
                            // Data filled the block exactly: a pad-only block follows
                            pad_pending_n = 1'b1;
                            last_n        = 1'b0;
                            cnt_n         = '0;
                            state_n       = OUT;
                        end else begin
                            cnt_n       = cnt + CW'(1);
                            first_pad_n = 1'b1;
                            state_n     = PAD;
                        end
                    end else begin
                        first_pad_n = 1'b1;
                        state_n     = PAD;
                    end
                end
            end
            PAD: begin
                wr_en       = 1'b1;
                first_pad_n = 1'b0;
                if (first_pad) begin
                    wr_byte = cnt_full ? 8'h61 : 8'h60;
                end else begin
                    wr_byte = cnt_full ? 8'h01 : 8'h00;
                end
                if (cnt_full) begin
                    cnt_n   = '0;
                    last_n  = 1'b1;
                    state_n = OUT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OUT: begin
                if (block_ready) begin
                    if (pad_pending) begin
                        pad_pending_n = 1'b0;
                        first_pad_n   = 1'b1;
                        state_n       = PAD;
                    end else begin
                        state_n = FILL;
                    end
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            shreg       <= '0;
            cnt         <= '0;
            pad_pending <= 1'b0;
            first_pad   <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pad_pending <= pad_pending_n;
            first_pad   <= first_pad_n;
            last_r      <= last_n;
            if (wr_en) begin
                shreg <= {shreg[R-9:0], wr_byte};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha3_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha3_padder
// Brief    : Directed self-checking bench for sha3_padder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_padder;
    localparam int R  = 1088;
    localparam int RB = 136;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [R-1:0] block;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    sha3_padder #(.D(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           passed = 0;
    int           total  = 0;
    logic [7:0]   msg [0:299];
    logic [R-1:0] got_blk [0:3];
    logic         got_last [0:3];
    int           got_n;
    int           last_accept;
    int           first_valid;
    logic [R-1:0] exp_blk;
    int           di;

    function automatic int diff_byte(input logic [R-1:0] a, input logic [R-1:0] b);
        for (int j = 0; j < RB; j++) begin
            if (a[R-1-8*j -: 8] !== b[R-1-8*j -: 8]) return j;
        end
        return 0;
    endfunction

    // Reference padding of msg[0:len-1], returning rate block k
    function automatic logic [R-1:0] ref_block(input int len, input int k);
        logic [R-1:0] v;
        logic [7:0]   p;
        int           idx;
        int           plen;
        v    = '0;
        plen = (len / RB + 1) * RB;
        for (int j = 0; j < RB; j++) begin
            idx = k * RB + j;
            p   = (idx < len) ? msg[idx] : 8'h00;
            if (idx == len)      p = p | 8'h60;
            if (idx == plen - 1) p = p | 8'h01;
            v = {v[R-9:0], p};
        end
        return v;
    endfunction

    task automatic send_msg(input int len, input bit empty_msg);
        int n;
        int t;
        n = empty_msg ? 1 : len;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = empty_msg ? 8'h00 : msg[i];
            in_last  = (i == n - 1);
            in_empty = empty_msg;
            t = 0;
            while (!in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                total++;
                $display("FAIL send_timeout: beat %0d in_ready=%b, required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            if (in_last) last_accept = cyc + 1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic recv_blocks(input int n, input int stall);
        logic [R-1:0] b0;
        logic         l0;
        bit           stable;
        int           t;
        got_n       = 0;
        first_valid = -1;
        for (int k = 0; k < 4; k++) begin
            got_blk[k]  = '0;
            got_last[k] = 1'bx;
        end
        block_ready = (stall == 0);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!block_valid && t < 3000) begin
                @(negedge clk);
                t++;
            end
            total++;
            if (block_valid !== 1'b1) begin
                $display("FAIL recv_timeout: block %0d block_valid=%b, required 1", k, block_valid);
                block_ready = 1'b0;
                return;
            end else passed++;
            if (k == 0) first_valid = cyc;
            b0 = block;
            l0 = block_last;
            if (stall > 0) begin
                stable = 1'b1;
                for (int s = 0; s < stall; s++) begin
                    if (block !== b0 || block_last !== l0 || block_valid !== 1'b1 || in_ready !== 1'b0)
                        stable = 1'b0;
                    @(negedge clk);
                end
                total++;
                if (stable !== 1'b1)
                    $display("FAIL stall_stable: block %0d stable=%b, required 1", k, stable);
                else passed++;
                block_ready = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            got_blk[k]  = b0;
            got_last[k] = l0;
            got_n++;
            total++;
            if (block_valid !== 1'b0)
                $display("FAIL valid_drop: block %0d block_valid=%b, required 0", k, block_valid);
            else passed++;
            if (l0 === 1'b1) begin
                total++;
                if (in_ready !== 1'b1)
                    $display("FAIL fill_resume: block %0d in_ready=%b, required 1", k, in_ready);
                else passed++;
            end
            if (stall > 0) block_ready = 1'b0;
        end
        block_ready = 1'b0;
    endtask

    task automatic check_blk(input string name, input int k, input logic [R-1:0] exp, input logic exp_last);
        total++;
        if (got_blk[k] !== exp) begin
            di = diff_byte(got_blk[k], exp);
            $display("FAIL %s: block %0d byte %0d got %h, required %h", name, k, di,
                     got_blk[k][R-1-8*di -: 8], exp[R-1-8*di -: 8]);
        end else passed++;
        total++;
        if (got_last[k] !== exp_last)
            $display("FAIL %s_last: block %0d block_last=%b, required %b", name, k, got_last[k], exp_last);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready);
        else passed++;
        total++;
        if (block_valid !== 1'b0) $display("FAIL rst_block_valid: got %b, required 0", block_valid);
        else passed++;
        total++;
        if (block_last !== 1'b0) $display("FAIL rst_block_last: got %b, required 0", block_last);
        else passed++;
        total++;
        if (block !== '0) $display("FAIL rst_block: got nonzero block, required all zero");
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b, required 1", in_ready);
        else passed++;
    endtask

    task automatic test_abc(input string name);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        fork
            send_msg(3, 1'b0);
            recv_blocks(1, 0);
        join
        total++;
        if (first_valid - last_accept !== 133)
            $display("FAIL %s_latency: got %0d cycles, required 133", name, first_valid - last_accept);
        else passed++;
        exp_blk = {8'h61, 8'h62, 8'h63, 8'h60, {131{8'h00}}, 8'h01};
        check_blk(name, 0, exp_blk, 1'b1);
    endtask

    task automatic test_empty();
        fork
            send_msg(0, 1'b1);
            recv_blocks(1, 0);
        join
        total++;
        if (first_valid - last_accept !== 136)
            $display("FAIL empty_latency: got %0d cycles, required 136", first_valid - last_accept);
        else passed++;
        exp_blk = {8'h60, {134{8'h00}}, 8'h01};
        check_blk("empty", 0, exp_blk, 1'b1);
    endtask

    task automatic test_135();
        for (int i = 0; i < 135; i++) msg[i] = 8'hAA;
        fork
            send_msg(135, 1'b0);
            recv_blocks(1, 0);
        join
        total++;
        if (first_valid - last_accept !== 1)
            $display("FAIL len135_latency: got %0d cycles, required 1", first_valid - last_accept);
        else passed++;
        exp_blk = {{135{8'hAA}}, 8'h61};
        check_blk("len135", 0, exp_blk, 1'b1);
    endtask

    task automatic test_136();
        for (int i = 0; i < 136; i++) msg[i] = 8'h55;
        fork
            send_msg(136, 1'b0);
            recv_blocks(2, 0);
        join
        exp_blk = {136{8'h55}};
        check_blk("len136_data", 0, exp_blk, 1'b0);
        exp_blk = {8'h60, {134{8'h00}}, 8'h01};
        check_blk("len136_pad", 1, exp_blk, 1'b1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 300; i++) msg[i] = 8'(i);
        fork
            send_msg(300, 1'b0);
            recv_blocks(3, 10);
        join
        total++;
        if (got_n !== 3) $display("FAIL stall_count: got %0d blocks, required 3", got_n);
        else passed++;
        check_blk("stall_b0", 0, ref_block(300, 0), 1'b0);
        check_blk("stall_b1", 1, ref_block(300, 1), 1'b0);
        check_blk("stall_b2", 2, ref_block(300, 2), 1'b1);
    endtask

    task automatic test_reset_mid();
        bit quiet;
        block_ready = 1'b0;
        msg[0] = 8'h11; msg[1] = 8'h22;
        send_msg(2, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b, required 0", in_ready);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (block_valid !== 1'b0 || block_last !== 1'b0 || block !== '0 || in_ready !== 1'b1)
            $display("FAIL midrst_state: valid=%b last=%b in_ready=%b, required 0 0 1 with zero block",
                     block_valid, block_last, in_ready);
        else passed++;
        quiet = 1'b1;
        repeat (150) begin
            if (block_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        total++;
        if (quiet !== 1'b1) $display("FAIL midrst_stale: stale block seen=%b, required 0", !quiet);
        else passed++;
        test_abc("midrst_abc");
    endtask

    task automatic test_back_to_back();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        fork
            begin
                send_msg(3, 1'b0);
                send_msg(3, 1'b0);
            end
            recv_blocks(2, 0);
        join
        exp_blk = {8'h61, 8'h62, 8'h63, 8'h60, {131{8'h00}}, 8'h01};
        check_blk("b2b_first", 0, exp_blk, 1'b1);
        check_blk("b2b_second", 1, exp_blk, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_empty    = 1'b0;
        block_ready = 1'b0;
        last_accept = 0;
        test_reset();
        test_abc("abc");
        test_empty();
        test_135();
        test_136();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
